traffic_intersection_ctrl: RTL and testbench
============================================

# traffic_intersection_ctrl

- Parametrised successor to the fixed-timing traffic light controller.
- Sequences a main/side intersection with a pedestrian walk phase.
- All durations, and the clock-to-second prescale, are set by parameters; the sensor extends both main and side green.
- Sits directly between the board clock/buttons and the light drivers.
- Exposes state and second count for debug.

## Interface
- CLK_PER_SEC, 100_000_000: clock cycles per one-second tick; ≥1.
- MAIN_GREEN_S, 6: base main-green seconds; 1..255.
- SIDE_GREEN_S, 3: base side-green seconds; 1..255.
- YELLOW_S, 2: yellow seconds (both roads); 1..255.
- SENSOR_EXT_S, 3: green extension seconds when Sensor seen; 0..255.
- WALK_S, 3: walk phase seconds; 1..255.
- clk  in  1  sole clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- Sensor  in  1  side-road vehicle sensor, level.
- walkButton  in  1  pedestrian request, any pulse ≥1 cycle.
- night  in  1  flash-mode request (present only with NIGHT_FLASH_EN).
- mainLight  out  2  main road lamp: 01 green, 10 yellow, 11 red, 00 off.
- sideLight  out  2  side road lamp, same encoding.
- walkLight  out  1  walk lamp.
- state  out  3  current state code.
- seconds_passed  out  8  whole seconds elapsed in current state.

## Operation
- States and codes:
  - MG=0: main 01, side 11.
  - MY=1: main 10, side 11.
  - WALK=2: main 11, side 11, walk 1.
  - SG=3: main 11, side 01.
  - SY=4: main 11, side 10.
  - FLASH=5.
- walkLight is 0 in every state except WALK.
- MG lasts MAIN_GREEN_S. If Sensor=1 on any clock in MG base period, ext flag sets; MG then lasts MAIN_GREEN_S+SENSOR_EXT_S. Extension is applied once and does not re-extend.
- MG→MY.
- MY lasts YELLOW_S, then:
  - → WALK if walk latch set;
  - else → SG.
- WALK lasts WALK_S, then → SG.
- SG lasts SIDE_GREEN_S, extended once by SENSOR_EXT_S if Sensor=1 during its base period.
- SG→SY. SY lasts YELLOW_S, then → MG.
- Walk latch:
  - set by walkButton=1 on any clock;
  - cleared on the clock entering WALK;
  - set wins over clear on the same clock, so a press during WALK entry or WALK itself is served in the next cycle.
- Ext flag clears on every state entry.
- Arithmetic:
  - prescaler width is $clog2(CLK_PER_SEC), min 1;
  - seconds counter is 8 bits and saturates at 255, never wraps;
  - durations sum to at most 9 bits internally.

## Timing
- Reset (rst=1 at an edge) sets:
  - state=MG, mainLight=01, sideLight=11, walkLight=0;
  - seconds_passed=0, prescaler=0;
  - walk latch=0, ext flag=0, flash phase=0.
- Reset mid-operation overrides everything on the same edge.
- Tick: prescaler counts 0..CLK_PER_SEC-1. tick=1 on the cycle prescaler==CLK_PER_SEC-1.
- Each tick increments seconds_passed.
- Transition: on the edge where tick=1 and seconds_passed==duration-1, state updates. On that same edge:
  - seconds_passed and prescaler reset to 0;
  - lamp outputs update, since lamp outputs are registered from next state.
- Each state therefore lasts exactly duration×CLK_PER_SEC cycles.
- Sensor/walkButton on the transition cycle itself count toward the outgoing state.

## Configuration
- NIGHT_FLASH_EN defined:
  - night port exists.
  - In MG with night=1 at a tick, the next edge enters FLASH.
  - FLASH: mainLight alternates 10/00 and sideLight 11/00, toggling each tick, starting 10/11. walkLight=0 and the walk latch is held.
  - night=0 at a tick → MG with fresh timer.
- NIGHT_FLASH_EN undefined: no night port. State 5 is never reached.

## Test plan
All scenarios use CLK_PER_SEC=4, MAIN_GREEN_S=6, SIDE_GREEN_S=3, YELLOW_S=2, SENSOR_EXT_S=3, WALK_S=3.
- Reset then idle inputs → cycle of MG 24, MY 8, SG 12, SY 8 cycles (52 total), walkLight always 0, seconds_passed 0..5 in MG.
- Sensor=1 for one cycle at MG cycle 5 → MG lasts 36 cycles; a second Sensor pulse gives no further extension.
- walkButton pulse 1 cycle during MG → after MY: WALK 12 cycles with mainLight=sideLight=11, walkLight=1; then SG; latch clear, next loop has no WALK.
- Sensor=1 throughout SG → SG lasts 24 cycles, then SY 8.
- rst=1 for one cycle mid-SG → next edge: state=0, mainLight=01, sideLight=11, seconds_passed=0; MG full 24 cycles follows.
- (NIGHT_FLASH_EN) night=1 in MG → FLASH at next tick, main toggles 10/00 every 4 cycles; night=0 → MG at next tick.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_intersection_ctrl
// Description : Main/side intersection sequencer with pedestrian walk phase,
//               sensor-extended greens and optional night flash (NIGHT_FLASH_EN).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module traffic_intersection_ctrl #(
    parameter int CLK_PER_SEC  = 100_000_000,
    parameter int MAIN_GREEN_S = 6,
    parameter int SIDE_GREEN_S = 3,
    parameter int YELLOW_S     = 2,
    parameter int SENSOR_EXT_S = 3,
    parameter int WALK_S       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Sensor,
    input  logic       walkButton,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [1:0] mainLight,
    output logic [1:0] sideLight,
    output logic       walkLight,
    output logic [2:0] state,
    output logic [7:0] seconds_passed
);

    localparam int              c_PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_PER_SEC - 1);
    localparam logic [8:0]      c_MG_D      = 9'(MAIN_GREEN_S);
    localparam logic [8:0]      c_SG_D      = 9'(SIDE_GREEN_S);
    localparam logic [8:0]      c_Y_D       = 9'(YELLOW_S);
    localparam logic [8:0]      c_EXT_D     = 9'(SENSOR_EXT_S);
    localparam logic [8:0]      c_WALK_D    = 9'(WALK_S);

    localparam logic [1:0] c_OFF    = 2'b00;
    localparam logic [1:0] c_GREEN  = 2'b01;
    localparam logic [1:0] c_YELLOW = 2'b10;
    localparam logic [1:0] c_RED    = 2'b11;

    typedef enum logic [2:0] {
        S_MG    = 3'd0,
        S_MY    = 3'd1,
        S_WALK  = 3'd2,
        S_SG    = 3'd3,
        S_SY    = 3'd4,
        S_FLASH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_PW-1:0] r_presc;
    logic [8:0]      r_cnt;
    logic            r_walk;
    logic            r_ext;
    logic            r_flash;
    logic [1:0]      r_main;
    logic [1:0]      r_side;
    logic            r_walk_lamp;

    logic            w_tick;
    logic            w_night;
    logic            w_in_base;
    logic            w_ext_eff;
    logic            w_walk_eff;
    logic            w_done;
    logic            w_trans;
    logic            w_enter_walk;
    logic            w_flash_nxt;
    logic [8:0]      w_base;
    logic [8:0]      w_dur;
    logic [1:0]      w_main_nxt;
    logic [1:0]      w_side_nxt;
    logic            w_walk_lamp_nxt;

`ifdef NIGHT_FLASH_EN
    assign w_night = night;
`else
    assign w_night = 1'b0;
`endif

    assign w_tick       = (r_presc == c_PRESC_MAX);
    assign w_trans      = (w_next != r_state);
    assign w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);

    // Sensor and button on the closing cycle still belong to the outgoing state,
    // so they are folded in combinationally before the duration compare.
    always_comb begin
        w_base = 9'd0;
        case (r_state)
            S_MG:         w_base = c_MG_D;
            S_MY, S_SY:   w_base = c_Y_D;
            S_WALK:       w_base = c_WALK_D;
            S_SG:         w_base = c_SG_D;
            default:      w_base = 9'd0;
        endcase
        w_in_base  = ((r_state == S_MG) || (r_state == S_SG)) && (r_cnt < w_base);
        w_ext_eff  = r_ext | (Sensor & w_in_base);
        w_dur      = w_base + (w_ext_eff ? c_EXT_D : 9'd0);
        w_walk_eff = r_walk | walkButton;
        w_done     = w_tick && (r_cnt == (w_dur - 9'd1));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_MG: begin
                if (w_tick && w_night) begin
                    w_next = S_FLASH;
                end else if (w_done) begin
                    w_next = S_MY;
                end
            end
            S_MY: begin
                if (w_done) begin
                    w_next = w_walk_eff ? S_WALK : S_SG;
                end
            end
            S_WALK: begin
                if (w_done) begin
                    w_next = S_SG;
                end
            end
            S_SG: begin
                if (w_done) begin
                    w_next = S_SY;
                end
            end
            S_SY: begin
                if (w_done) begin
                    w_next = S_MG;
                end
            end
            S_FLASH: begin
                if (w_tick && !w_night) begin
                    w_next = S_MG;
                end
            end
            default: w_next = S_MG;
        endcase
    end

    // Lamps are registered from the next state so they change on the transition edge.
    always_comb begin
        w_flash_nxt     = ((r_state == S_FLASH) && (w_next == S_FLASH)) ? (r_flash ^ w_tick) : 1'b0;
        w_main_nxt      = c_RED;
        w_side_nxt      = c_RED;
        w_walk_lamp_nxt = 1'b0;
        case (w_next)
            S_MG:    w_main_nxt = c_GREEN;
            S_MY:    w_main_nxt = c_YELLOW;
            S_WALK:  w_walk_lamp_nxt = 1'b1;
            S_SG:    w_side_nxt = c_GREEN;
            S_SY:    w_side_nxt = c_YELLOW;
            S_FLASH: begin
                w_main_nxt = w_flash_nxt ? c_OFF : c_YELLOW;
                w_side_nxt = w_flash_nxt ? c_OFF : c_RED;
            end
            default: begin
                w_main_nxt = c_GREEN;
                w_side_nxt = c_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_MG;
            r_main      <= c_GREEN;
            r_side      <= c_RED;
            r_walk_lamp <= 1'b0;
            r_flash     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_main      <= w_main_nxt;
            r_side      <= w_side_nxt;
            r_walk_lamp <= w_walk_lamp_nxt;
            r_flash     <= w_flash_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_cnt   <= 9'd0;
            r_ext   <= 1'b0;
            r_walk  <= 1'b0;
        end else begin
            r_walk <= walkButton | (r_walk & ~w_enter_walk);
            if (w_trans) begin
                r_presc <= '0;
                r_cnt   <= 9'd0;
                r_ext   <= 1'b0;
            end else begin
                r_presc <= w_tick ? '0 : (r_presc + 1'b1);
                if (w_tick && (r_cnt != 9'h1FF)) begin
                    r_cnt <= r_cnt + 9'd1;
                end
                r_ext <= w_ext_eff;
            end
        end
    end

    // Timing runs on a 9-bit count so extended greens past 255 s still end.
    assign seconds_passed = r_cnt[8] ? 8'hFF : r_cnt[7:0];
    assign state          = r_state;
    assign mainLight      = r_main;
    assign sideLight      = r_side;
    assign walkLight      = r_walk_lamp;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_intersection_ctrl
// Description : Scenario-table bench with per-cycle expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_intersection_ctrl;

    localparam int CPS = 4;

    localparam logic [2:0] MG = 3'd0;
    localparam logic [2:0] MY = 3'd1;
    localparam logic [2:0] WK = 3'd2;
    localparam logic [2:0] SG = 3'd3;
    localparam logic [2:0] SY = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Sensor = 1'b0;
    logic       walkButton = 1'b0;
`ifdef NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif
    logic [1:0] mainLight;
    logic [1:0] sideLight;
    logic       walkLight;
    logic [2:0] state;
    logic [7:0] seconds_passed;

    traffic_intersection_ctrl #(
        .CLK_PER_SEC  (CPS),
        .MAIN_GREEN_S (6),
        .SIDE_GREEN_S (3),
        .YELLOW_S     (2),
        .SENSOR_EXT_S (3),
        .WALK_S       (3)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .Sensor         (Sensor),
        .walkButton     (walkButton),
`ifdef NIGHT_FLASH_EN
        .night          (night),
`endif
        .mainLight      (mainLight),
        .sideLight      (sideLight),
        .walkLight      (walkLight),
        .state          (state),
        .seconds_passed (seconds_passed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        int         len;
    } seg_t;

    typedef struct {
        string name;
        int    nseg;
        int    rst_at;
        int    sens_lo;
        int    sens_hi;
        int    sens2;
        int    walk_at;
    } scen_t;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] ml;
        logic [1:0] sl;
        logic       wl;
        logic [7:0] secs;
    } exp_t;

    exp_t  sb[$];
    seg_t  segs[6][10];
    scen_t scen[6];
    int    checks = 0;
    int    errors = 0;

    function automatic seg_t mk(input logic [2:0] st, input int len);
        seg_t s;
        s.st  = st;
        s.len = len;
        return s;
    endfunction

    // Lamp pattern {main, side, walk} for each sequencing state.
    function automatic logic [4:0] lamps(input logic [2:0] st);
        case (st)
            MG:      return 5'b01_11_0;
            MY:      return 5'b10_11_0;
            WK:      return 5'b11_11_1;
            SG:      return 5'b11_01_0;
            SY:      return 5'b11_10_0;
            default: return 5'b00_00_0;
        endcase
    endfunction

    task automatic do_cycle(input logic r, input logic s, input logic w,
                            input string name, input int n);
        exp_t e;
        exp_t a;
        rst        = r;
        Sensor     = s;
        walkButton = w;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        a = {state, mainLight, sideLight, walkLight, seconds_passed};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: got st=%0d main=%b side=%b walk=%b sec=%0d, want st=%0d main=%b side=%b walk=%b sec=%0d",
                     name, n, a.st, a.ml, a.sl, a.wl, a.secs, e.st, e.ml, e.sl, e.wl, e.secs);
        end
    endtask

    initial begin
        scen[0] = '{"idle_reset",  4,  0, -1, -2, -1, -1};
        segs[0][0] = mk(MG, 24); segs[0][1] = mk(MY, 8);
        segs[0][2] = mk(SG, 12); segs[0][3] = mk(SY, 8);

        scen[1] = '{"mg_sensor",   4, -1,  5,  5, 30, -1};
        segs[1][0] = mk(MG, 36); segs[1][1] = mk(MY, 8);
        segs[1][2] = mk(SG, 12); segs[1][3] = mk(SY, 8);

        scen[2] = '{"walk_press",  9, -1, -1, -2, -1, 10};
        segs[2][0] = mk(MG, 24); segs[2][1] = mk(MY, 8); segs[2][2] = mk(WK, 12);
        segs[2][3] = mk(SG, 12); segs[2][4] = mk(SY, 8); segs[2][5] = mk(MG, 24);
        segs[2][6] = mk(MY, 8);  segs[2][7] = mk(SG, 12); segs[2][8] = mk(SY, 8);

        scen[3] = '{"sg_sensor",   4, -1, 32, 55, -1, -1};
        segs[3][0] = mk(MG, 24); segs[3][1] = mk(MY, 8);
        segs[3][2] = mk(SG, 24); segs[3][3] = mk(SY, 8);

        // Sensor on MG's closing cycle extends it; button on the WALK-entry edge re-arms the latch.
        scen[4] = '{"edge_inputs", 10, -1, -1, -2, 24, 44};
        segs[4][0] = mk(MG, 36); segs[4][1] = mk(MY, 8); segs[4][2] = mk(WK, 12);
        segs[4][3] = mk(SG, 12); segs[4][4] = mk(SY, 8); segs[4][5] = mk(MG, 24);
        segs[4][6] = mk(MY, 8);  segs[4][7] = mk(WK, 12); segs[4][8] = mk(SG, 12);
        segs[4][9] = mk(SY, 8);

        scen[5] = '{"reset_mid_sg", 5, 37, -1, -2, -1, -1};
        segs[5][0] = mk(MG, 24); segs[5][1] = mk(MY, 8); segs[5][2] = mk(SG, 5);
        segs[5][3] = mk(MG, 24); segs[5][4] = mk(MY, 8);

        for (int k = 0; k < 6; k++) begin
            int n;
            for (int j = 0; j < scen[k].nseg; j++) begin
                for (int i = 0; i < segs[k][j].len; i++) begin
                    exp_t e;
                    logic [4:0] lp;
                    lp     = lamps(segs[k][j].st);
                    e.st   = segs[k][j].st;
                    e.ml   = lp[4:3];
                    e.sl   = lp[2:1];
                    e.wl   = lp[0];
                    e.secs = 8'(i / CPS);
                    sb.push_back(e);
                end
            end
            n = 0;
            while (sb.size() > 0) begin
                do_cycle(n == scen[k].rst_at,
                         ((n >= scen[k].sens_lo) && (n <= scen[k].sens_hi)) || (n == scen[k].sens2),
                         n == scen[k].walk_at,
                         scen[k].name, n);
                n++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
